heartbeat_sense: RTL and testbench

- Sense front-end that produces the `heartbeat_in` pulse consumed by the pacing timer.
- Converts a rectified, sampled cardiac signal into single-cycle beat events using threshold detection with hysteresis and a refractory period.
- Blanks detection after each pace pulse, so the pace artifact is not sensed as an intrinsic beat.
- Sits between the ADC sample stream and the pacer's `heartbeat_in`; the pacer's `pace_out` is fed back into this block's `pace_in`.

---
 rtl/heartbeat_sense_pkg.sv | 20 ++
 rtl/beat_interval_counter.sv | 47 ++++
 rtl/heartbeat_sense.sv | 139 +++++++++++++
 tb/tb_heartbeat_sense.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/heartbeat_sense_pkg.sv
// rtl/heartbeat_sense_pkg.sv - shared types and default widths for the heartbeat sense front-end
//
// Contents:
//   sense_state_e   - detection FSM state, 2-bit encoding (also driven out on sense_state)
//   SAMPLE_W_DEF    - default sample / threshold width
//   CNT_W_DEF       - default width of the shared refractory/blanking down-counter
//   INTERVAL_W_DEF  - default width of the R-R interval counter
package heartbeat_sense_pkg;

  localparam int SAMPLE_W_DEF   = 8;
  localparam int CNT_W_DEF      = 16;
  localparam int INTERVAL_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_REFRACT = 2'd1,
    ST_BLANK   = 2'd2
  } sense_state_e;

endpackage

// File: rtl/beat_interval_counter.sv
// rtl/beat_interval_counter.sv - saturating beat-to-beat interval counter with restart and latch
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   restart  in   restart the count from 0 without reporting (pace reference)
//   latch    in   beat detected: report count+1 and restart from 0
//   interval out  last reported interval in clk cycles
//   valid    out  one-cycle pulse when interval updates
module beat_interval_counter
  import heartbeat_sense_pkg::*;
#(
  parameter int W = INTERVAL_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         restart,
  input  logic         latch,
  output logic [W-1:0] interval,
  output logic         valid
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_inc;

  // Saturating increment: an absurdly long gap reports all-ones, never wraps.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      interval <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= latch;
      if (latch) begin
        interval <= cnt_inc;
      end
      if (restart || latch) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/heartbeat_sense.sv
// rtl/heartbeat_sense.sv - threshold/hysteresis beat detector with refractory and pace blanking
//
// Optional feature macro: BEAT_INTERVAL_EN (adds rr_interval / rr_valid and the interval counter)
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   sample_valid   in   sample is valid this cycle
//   sample         in   unsigned rectified signal magnitude
//   thresh_hi      in   detection threshold (sample >= thresh_hi)
//   thresh_lo      in   release threshold (sample <= thresh_lo)
//   pace_in        in   pace pulse from the pacer, starts blanking
//   heartbeat_out  out  one-cycle beat pulse to the pacer
//   rr_interval    out  last beat-to-beat interval (BEAT_INTERVAL_EN only)
//   rr_valid       out  pulses with heartbeat_out when rr_interval updates (BEAT_INTERVAL_EN only)
//   sense_state    out  current FSM state, 0=ARMED 1=REFRACT 2=BLANK
module heartbeat_sense
  import heartbeat_sense_pkg::*;
#(
  parameter int SAMPLE_W       = SAMPLE_W_DEF,
  parameter int REFRACT_CYCLES = 32,
  parameter int BLANK_CYCLES   = 16,
  parameter int CNT_W          = CNT_W_DEF
`ifdef BEAT_INTERVAL_EN
  ,
  parameter int INTERVAL_W     = INTERVAL_W_DEF
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  input  logic [SAMPLE_W-1:0]   sample,
  input  logic [SAMPLE_W-1:0]   thresh_hi,
  input  logic [SAMPLE_W-1:0]   thresh_lo,
  input  logic                  pace_in,
  output logic                  heartbeat_out,
`ifdef BEAT_INTERVAL_EN
  output logic [INTERVAL_W-1:0] rr_interval,
  output logic                  rr_valid,
`endif
  output logic [1:0]            sense_state
);

  localparam logic [CNT_W-1:0] REFRACT_LOAD = CNT_W'(REFRACT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD   = CNT_W'(BLANK_CYCLES - 1);

  sense_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rel_q, rel_d;
  logic             beat_q, beat_d;
  logic             hit;
  logic             rel_smp;

  assign hit     = sample_valid && (sample >= thresh_hi);
  assign rel_smp = sample_valid && (sample <= thresh_lo);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARMED;
      cnt_q   <= '0;
      rel_q   <= 1'b0;
      beat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    beat_d  = 1'b0;
    if (pace_in) begin
      // Pace wins over detection in every state; in BLANK this re-extends blanking.
      state_d = ST_BLANK;
      cnt_d   = BLANK_LOAD;
      rel_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (hit) begin
            state_d = ST_REFRACT;
            cnt_d   = REFRACT_LOAD;
            rel_d   = 1'b0;
            beat_d  = 1'b1;
          end
        end
        ST_REFRACT: begin
          // Release may be seen at any point of the refractory window, but the
          // block only re-arms once the window has fully elapsed.
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            rel_d = rel_q | rel_smp;
          end else if (rel_q || rel_smp) begin
            state_d = ST_ARMED;
            rel_d   = 1'b0;
          end
        end
        ST_BLANK: begin
          // Everything is ignored here; exiting into REFRACT with a clear flag
          // forces a fresh release sample before the next detection.
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = ST_REFRACT;
            rel_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_ARMED;
          cnt_d   = '0;
          rel_d   = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    heartbeat_out = beat_q;
    sense_state   = state_q;
  end

`ifdef BEAT_INTERVAL_EN
  beat_interval_counter #(
    .W (INTERVAL_W)
  ) u_interval (
    .clk      (clk),
    .rst      (rst),
    .restart  (pace_in),
    .latch    (beat_d),
    .interval (rr_interval),
    .valid    (rr_valid)
  );
`endif

endmodule

// File: tb/tb_heartbeat_sense.sv
// tb/tb_heartbeat_sense.sv - directed self-checking bench for heartbeat_sense
module tb_heartbeat_sense;

  logic       clk;
  logic       rst;
  logic       sample_valid;
  logic [7:0] sample;
  logic [7:0] thresh_hi;
  logic [7:0] thresh_lo;
  logic       pace_in;
  logic       heartbeat_out;
  logic [1:0] sense_state;
`ifdef BEAT_INTERVAL_EN
  logic [31:0] rr_interval;
  logic        rr_valid;
`endif

  int total = 0;
  int bad   = 0;

  heartbeat_sense #(
    .SAMPLE_W       (8),
    .REFRACT_CYCLES (10),
    .BLANK_CYCLES   (5),
    .CNT_W          (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_valid  (sample_valid),
    .sample        (sample),
    .thresh_hi     (thresh_hi),
    .thresh_lo     (thresh_lo),
    .pace_in       (pace_in),
    .heartbeat_out (heartbeat_out),
`ifdef BEAT_INTERVAL_EN
    .rr_interval   (rr_interval),
    .rr_valid      (rr_valid),
`endif
    .sense_state   (sense_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of input, then look at the outputs 1 time unit after the edge.
  task automatic cyc(input int s, input logic p);
    sample  = 8'(s);
    pace_in = p;
    @(posedge clk);
    #1;
  endtask

  // From REFRACT just after a beat: ten low samples bring the block back to ARMED.
  task automatic rearm(input string tag);
    for (int i = 0; i < 10; i++) cyc(30, 1'b0);
    chk(tag, int'(sense_state), 0);
  endtask

  int beats;

  initial begin
    rst          = 1'b1;
    sample_valid = 1'b1;
    sample       = 8'd0;
    thresh_hi    = 8'd100;
    thresh_lo    = 8'd40;
    pace_in      = 1'b0;
    cyc(0, 1'b0);
    cyc(200, 1'b0);
    chk("reset_hb", int'(heartbeat_out), 0);
    chk("reset_state", int'(sense_state), 0);
    rst = 1'b0;

    // Basic beat: 20,120,120,30...
    cyc(20, 1'b0);
    chk("basic_idle_hb", int'(heartbeat_out), 0);
    cyc(120, 1'b0);
    chk("basic_beat", int'(heartbeat_out), 1);
    chk("basic_refract", int'(sense_state), 1);
    beats = 0;
    for (int i = 1; i <= 9; i++) begin
      cyc((i == 1) ? 120 : 30, 1'b0);
      beats += int'(heartbeat_out);
      chk("basic_refract_hold", int'(sense_state), 1);
    end
    chk("basic_single_pulse", beats, 0);
    cyc(30, 1'b0);
    chk("basic_rearm", int'(sense_state), 0);

    // Hysteresis: mid-level samples never release
    cyc(110, 1'b0);
    chk("hyst_beat1", int'(heartbeat_out), 1);
    beats = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(70, 1'b0);
      beats += int'(heartbeat_out);
    end
    chk("hyst_no_beat", beats, 0);
    chk("hyst_stuck_refract", int'(sense_state), 1);
    cyc(30, 1'b0);
    chk("hyst_rearm", int'(sense_state), 0);
    cyc(110, 1'b0);
    chk("hyst_beat2", int'(heartbeat_out), 1);
    rearm("hyst_back_armed");

    // Blanking: pace while sample is large
    cyc(200, 1'b1);
    chk("blank_no_beat", int'(heartbeat_out), 0);
    chk("blank_enter", int'(sense_state), 2);
    for (int i = 0; i < 4; i++) begin
      cyc(200, 1'b0);
      chk("blank_hold", int'(sense_state), 2);
    end
    cyc(200, 1'b0);
    chk("blank_to_refract", int'(sense_state), 1);
    chk("blank_exit_no_beat", int'(heartbeat_out), 0);
    cyc(200, 1'b0);
    chk("blank_wait_release", int'(sense_state), 1);
    cyc(30, 1'b0);
    chk("blank_rearm", int'(sense_state), 0);

    // Blanking extension: second pace at blank cycle 3, low samples ignored
    cyc(200, 1'b1);
    cyc(30, 1'b0);
    cyc(30, 1'b1);
    chk("blank_ext_reload", int'(sense_state), 2);
    for (int i = 0; i < 4; i++) begin
      cyc(30, 1'b0);
      chk("blank_ext_hold", int'(sense_state), 2);
    end
    cyc(30, 1'b0);
    chk("blank_ext_exit", int'(sense_state), 1);
    cyc(30, 1'b0);
    chk("blank_ext_rearm", int'(sense_state), 0);

    // Pace and detection in the same cycle
    cyc(150, 1'b1);
    chk("simul_no_beat", int'(heartbeat_out), 0);
    chk("simul_blank", int'(sense_state), 2);
    cyc(150, 1'b0);
    chk("simul_no_beat_late", int'(heartbeat_out), 0);
    for (int i = 0; i < 4; i++) cyc(30, 1'b0);
    chk("simul_refract", int'(sense_state), 1);
    cyc(30, 1'b0);
    chk("simul_rearm", int'(sense_state), 0);

    // Invalid samples are never detected
    sample_valid = 1'b0;
    cyc(250, 1'b0);
    chk("invalid_no_beat", int'(heartbeat_out), 0);
    chk("invalid_armed", int'(sense_state), 0);
    sample_valid = 1'b1;

    // Reset in refractory cycle 4
    cyc(150, 1'b0);
    chk("rstmid_beat", int'(heartbeat_out), 1);
    for (int i = 0; i < 3; i++) cyc(150, 1'b0);
    chk("rstmid_in_refract", int'(sense_state), 1);
    rst = 1'b1;
    cyc(150, 1'b0);
    chk("rstmid_armed", int'(sense_state), 0);
    chk("rstmid_hb", int'(heartbeat_out), 0);
    rst = 1'b0;
    cyc(150, 1'b0);
    chk("rstmid_beat_after", int'(heartbeat_out), 1);
    rearm("rstmid_back_armed");

    // Overlapping thresholds: release sample also satisfies detection
    thresh_lo = 8'd120;
    cyc(110, 1'b0);
    chk("ovl_beat1", int'(heartbeat_out), 1);
    for (int i = 0; i < 9; i++) cyc(110, 1'b0);
    chk("ovl_refract_end", int'(sense_state), 1);
    cyc(110, 1'b0);
    chk("ovl_release", int'(sense_state), 0);
    chk("ovl_no_beat_on_release", int'(heartbeat_out), 0);
    cyc(110, 1'b0);
    chk("ovl_beat2", int'(heartbeat_out), 1);
    thresh_lo = 8'd40;
    rearm("ovl_back_armed");

`ifdef BEAT_INTERVAL_EN
    rst = 1'b1;
    cyc(0, 1'b0);
    rst = 1'b0;
    chk("rr_reset_val", int'(rr_interval), 0);
    chk("rr_reset_valid", int'(rr_valid), 0);
    for (int i = 0; i < 3; i++) cyc(30, 1'b0);
    cyc(150, 1'b0);
    chk("rr_first_valid", int'(rr_valid), 1);
    chk("rr_first_since_reset", int'(rr_interval), 4);
    for (int i = 0; i < 249; i++) cyc(30, 1'b0);
    cyc(150, 1'b0);
    chk("rr_second_hb", int'(heartbeat_out), 1);
    chk("rr_second_valid", int'(rr_valid), 1);
    chk("rr_second_interval", int'(rr_interval), 250);
    cyc(30, 1'b0);
    chk("rr_valid_drop", int'(rr_valid), 0);
    for (int i = 0; i < 9; i++) cyc(30, 1'b0);
    for (int i = 0; i < 5; i++) cyc(30, 1'b0);
    cyc(30, 1'b1);
    chk("rr_no_valid_on_pace", int'(rr_valid), 0);
    for (int i = 0; i < 5; i++) cyc(30, 1'b0);
    cyc(30, 1'b0);
    chk("rr_pace_rearm", int'(sense_state), 0);
    for (int i = 0; i < 7; i++) cyc(30, 1'b0);
    cyc(150, 1'b0);
    chk("rr_after_pace", int'(rr_interval), 14);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
